// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: off pattern, hex glyph table,
// slot states and a counter-width helper.
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-low gfedcba glyphs, indexed by nibble value
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      SLOT_GUARD,
      SLOT_DRIVE
   } slot_e;

   function automatic int cnt_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous commit.
// Optional leading-zero suppression: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 500
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    load,
   output logic                    pending,
   output logic                    frame_tick,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int CNT_W = cnt_w(REFRESH_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

   typedef struct packed {
      logic [NUM_DIGITS-1:0][3:0] val;
      logic [NUM_DIGITS-1:0]      dp;
      logic [NUM_DIGITS-1:0]      blank;
   } frame_t;

   localparam frame_t FRAME_RST = '{val: '0, dp: '0, blank: '1};

   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   frame_t                shadow, disp, incoming;
   logic                  live;
   logic                  boundary;
   slot_e                 slot;
   logic [3:0]            nib;
   logic [6:0]            hex;
   logic [NUM_DIGITS-1:0] lz;
   logic [NUM_DIGITS-1:0] blank_eff;
   logic [7:0]            seg_nxt;
   logic [NUM_DIGITS-1:0] an_nxt;

   assign incoming.val   = value_in;
   assign incoming.dp    = dp_in;
   assign incoming.blank = blank_in;

   assign boundary = (cnt == CNT_MAX) && (idx == IDX_MAX);

   // Prescaler and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
         idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Shadow capture and frame-boundary commit; a load on the boundary bypasses the shadow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow     <= FRAME_RST;
         disp       <= FRAME_RST;
         pending    <= 1'b0;
         live       <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= boundary;
         if (load && boundary) begin
            shadow  <= incoming;
            disp    <= incoming;
            pending <= 1'b0;
            live    <= 1'b1;
         end else if (load) begin
            shadow  <= incoming;
            pending <= 1'b1;
         end else if (boundary && pending) begin
            disp    <= shadow;
            pending <= 1'b0;
            live    <= 1'b1;
         end
      end
   end

`ifdef SEG_SCAN_LZ_BLANK_EN
   logic zabove;

   always_comb begin
      lz     = '0;
      zabove = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zabove = zabove & (disp.val[k] == 4'h0);
         lz[k]  = zabove;
      end
   end
`else
   assign lz = '0;
`endif

   assign blank_eff = disp.blank | lz;
   assign nib       = disp.val[idx];

   seg_hex_decode u_dec (
      .nib (nib),
      .seg (hex)
   );

   // Anodes stay off until the first commit so the cleared display is fully dark
   always_comb begin
      slot    = (cnt < GUARD_C) ? SLOT_GUARD : SLOT_DRIVE;
      an_nxt  = '1;
      seg_nxt = SEG_OFF;
      if (slot == SLOT_DRIVE && live) begin
         an_nxt[idx] = 1'b0;
         if (!blank_eff[idx])
            seg_nxt = {~disp.dp[idx], hex};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= SEG_OFF;
         an  <= '1;
      end else begin
         seg <= seg_nxt;
         an  <= an_nxt;
      end
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scanner for a common-anode multi-digit seven-segment display. It feeds one shared hex-to-segment decoder and drives the active-low digit anodes. Hex values are loaded through a load strobe and committed only at frame boundaries, so the display never tears. The block sits between the datapath result registers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
REFRESH_DIV, 50000, clock cycles per digit slot; must be greater than GUARD.
GUARD, 500, anti-ghosting dead cycles at the start of each slot; anodes are all off during these cycles.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
value_in  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k; digit 0 is least significant
dp_in  in  NUM_DIGITS  decimal point request per digit; active-high
blank_in  in  NUM_DIGITS  per-digit force-off; active-high; captured together with value_in
load  in  1  one-cycle strobe that captures value_in, dp_in and blank_in into the shadow register
pending  out  1  high while a shadow value waits for a frame boundary
frame_tick  out  1  one-cycle pulse registered at each frame boundary
seg  out  8  cathodes, active-low; bit7 = DP, bits6..0 = g..a
an  out  NUM_DIGITS  anodes, active-low, one-hot or all-ones

Behaviour:
- Reset (async, rst=1): an=all 1s, seg=8'hFF, pending=0, frame_tick=0. Prescaler cnt=0, digit index idx=0, shadow and display registers cleared (values 0, dp 0, blank all 1s so the display stays dark until the first commit).
- Reset mid-operation: all of the above applies immediately; a pending load is discarded.
- Prescaler: cnt counts 0..REFRESH_DIV-1 and wraps. When cnt==REFRESH_DIV-1, idx advances by 1, wrapping from NUM_DIGITS-1 to 0.
- Slot states, decoded from cnt:
  - GUARD_OFF when cnt<GUARD: an=all 1s, seg=8'hFF.
  - DRIVE otherwise: an[idx]=0, all other an bits 1, seg = decode(display nibble idx) with bit7 = ~dp[idx].
  - If blank[idx]=1 in DRIVE: seg=8'hFF and an[idx] is still driven low.
- seg and an are registered, so they lag the cnt/idx state by exactly 1 cycle.
- Frame boundary: cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1. On that edge frame_tick=1 for one cycle (next cycle). If pending=1, display<=shadow and pending<=0.
- Load: on a load cycle, shadow<=inputs and pending<=1.
- Load while pending: the shadow is overwritten; the last load wins.
- Load coincident with a frame boundary: the new inputs commit directly to the display register and pending stays 0.
- Worst-case commit latency: NUM_DIGITS*REFRESH_DIV cycles.
- Decoder encoding (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E (hex, before the DP bit)

Optional Feature:
Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression. A digit k>0 is blanked when its nibble and every higher nibble are 0. Digit 0 is never suppressed, so a value of 0 shows a single "0".
- The suppression mask is computed combinationally from the display register, then ORed with blank.
- Not defined: zeros always display; only blank_in blanks a digit.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_OFF = 8'hFF
  - the 16-entry hex segment constant array
  - localparam helper CNT_W = $clog2(REFRESH_DIV)
- Natural sub-module: seg_hex_decode, a combinational 4-bit to 7-bit active-low decoder instantiated once on the shared path.
- The scanner, shadow/commit logic and blanking stay in seg_scan_ctrl.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2):
1. Reset release with no load -> an=4'hF and seg=8'hFF for the first full frame (32 cycles); frame_tick first pulses at cycle 32 after release.
2. load with value_in=16'h12AF, dp_in=4'b0100, blank_in=0 mid-frame -> pending=1 until the boundary; next frame shows digit0=F(8E), digit1=A(88), digit2=2 with DP (24), digit3=1(F9). Each anode is low for cycles 2..7 of its slot and high for cycles 0..1.
3. Two loads in one frame (16'h1111, then 16'h2222) -> after the boundary all digits show seg=8'hA4; 1 is never displayed.
4. load asserted exactly on the boundary cycle with 16'h0005 -> pending stays 0; the next frame shows 5 (92) on digit0. Without SEG_SCAN_LZ_BLANK_EN, digits1-3 show C0; with it defined, they are blanked (FF).
5. rst asserted during DRIVE of digit 2 with pending=1 -> an=4'hF and seg=8'hFF asynchronously, pending=0; after release, idx restarts at 0 and the old display does not return.
6. blank_in=4'b1000 loaded with 16'h8888 -> digit3 slot: an=4'b0111, seg=8'hFF; digits 0-2 show 80.
